// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: one Wishbone classic link (request fields plus response).
//
// Handshake: a request is live while cyc and stb are both high; the request
// fields (we, sel, adr, dat_w) must stay stable until the slave answers with
// ack (or err) in the same cycle, which completes that single transfer. cyc may
// stay high across several transfers to keep the bus locked to one master.
interface wb_arbiter2_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [29:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone classic arbiter sharing one slave bus.
// Registered round-robin grant; the owner keeps the bus while its cyc is high.
// Optional stall watchdog enabled by defining WB_TIMEOUT_EN: after
// TIMEOUT_CYCLES unanswered wait states the owner gets a one-cycle err and the
// slave bus is parked until the owner releases cyc.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_arbiter2_if.slave         m0,
  wb_arbiter2_if.slave         m1,
  wb_arbiter2_if.master        s,
  output logic [1:0]           gnt
);

`ifdef WB_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;
  logic   last_q, last_d;   // most recent owner: 0 = m0, 1 = m1
  logic   wd_fire;          // watchdog expires this cycle

  // State and last-owner registers; last resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_q, wd_d;
  logic       own_stb;

  assign own_stb = ((state_q == ST_GNT0) && m0.stb) ||
                   ((state_q == ST_GNT1) && m1.stb);
  // An ack in the threshold cycle wins over the timeout.
  assign wd_fire = own_stb && !s.ack && (wd_q == WD_LAST);

  // Count unanswered strobe cycles; an ack or any state change restarts it.
  always_comb begin
    wd_d = wd_q;
    if ((state_d != state_q) || s.ack) begin
      wd_d = '0;
    end else if (own_stb) begin
      wd_d = wd_q + 8'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Next-state: round-robin on ties, hold while owner keeps cyc, hand over without a bubble.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
        end else if (m0.cyc) begin
          state_d = ST_GNT0;
        end else if (m1.cyc) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0.cyc) begin
          state_d = m1.cyc ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1.cyc) begin
          state_d = m0.cyc ? ST_GNT0 : ST_IDLE;
        end
      end
`ifdef WB_TIMEOUT_EN
      ST_ABORT: begin
        // The aborted owner is the last one granted; wait for it to let go.
        if (last_q && !m1.cyc) begin
          state_d = m0.cyc ? ST_GNT0 : ST_IDLE;
        end else if (!last_q && !m0.cyc) begin
          state_d = m1.cyc ? ST_GNT1 : ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef WB_TIMEOUT_EN
    if (wd_fire) begin
      state_d = ST_ABORT;
    end
`endif
    if (state_d == ST_GNT0) begin
      last_d = 1'b0;
    end else if (state_d == ST_GNT1) begin
      last_d = 1'b1;
    end
  end

  // Slave-bus mux and response routing, decoded from the registered state only.
  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.sel   = '0;
    s.adr   = '0;
    s.dat_w = '0;
    m0.ack  = 1'b0;
    m1.ack  = 1'b0;
    gnt     = 2'b00;
    case (state_q)
      ST_GNT0: begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.we    = m0.we;
        s.sel   = m0.sel;
        s.adr   = m0.adr;
        s.dat_w = m0.dat_w;
        m0.ack  = s.ack;
        gnt     = 2'b01;
      end
      ST_GNT1: begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.we    = m1.we;
        s.sel   = m1.sel;
        s.adr   = m1.adr;
        s.dat_w = m1.dat_w;
        m1.ack  = s.ack;
        gnt     = 2'b10;
      end
      default: ;
    endcase
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    m0.err   = wd_fire && (state_q == ST_GNT0);
    m1.err   = wd_fire && (state_q == ST_GNT1);
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed and randomized bench for wb_arbiter2 with a
// bus-ownership reference model. Define WB_TIMEOUT_EN to exercise the watchdog.
module tb_wb_arbiter2;
  localparam int TO = 4;
`ifdef WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  wb_arbiter2_if m0_bus ();
  wb_arbiter2_if m1_bus ();
  wb_arbiter2_if s_bus ();

  wb_arbiter2 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus),
    .gnt (gnt)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: who owns the bus (-1 nobody), whether that owner was
  // cut off by the watchdog, who owned it last, and how long the current
  // strobe has gone unanswered.
  int own;
  bit abrt;
  int last;
  int wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cyc_of(input int x);
    return (x == 0) ? m0_bus.cyc : m1_bus.cyc;
  endfunction

  function automatic bit stb_of(input int x);
    return (x == 0) ? m0_bus.stb : m1_bus.stb;
  endfunction

  function automatic bit exp_fire();
    return TO_EN && (own >= 0) && !abrt && stb_of(own) && !s_bus.ack && (wd == TO - 1);
  endfunction

  task automatic model_reset();
    own  = -1;
    abrt = 1'b0;
    last = 1;
    wd   = 0;
  endtask

  // Apply the ownership rules to the inputs present at a rising edge.
  task automatic model_advance();
    int p_own;
    bit p_abrt;
    bit own_stb;
    bit fire;
    p_own   = own;
    p_abrt  = abrt;
    own_stb = (own >= 0) && !abrt && stb_of(own);
    fire    = exp_fire();
    if (abrt) begin
      if (!cyc_of(own)) begin
        abrt = 1'b0;
        own  = cyc_of(1 - own) ? 1 - own : -1;
      end
    end else if (own < 0) begin
      if (m0_bus.cyc && m1_bus.cyc) own = (last == 0) ? 1 : 0;
      else if (m0_bus.cyc)          own = 0;
      else if (m1_bus.cyc)          own = 1;
    end else if (fire) begin
      abrt = 1'b1;
    end else if (!cyc_of(own)) begin
      own = cyc_of(1 - own) ? 1 - own : -1;
    end
    if (own >= 0 && !abrt) last = own;
    if (own != p_own || abrt != p_abrt || s_bus.ack) wd = 0;
    else if (own_stb) wd = wd + 1;
  endtask

  // Compare every DUT output against what the model says this cycle.
  task automatic check_all(input string tag);
    logic [1:0]  e_gnt;
    logic        e_cyc, e_stb, e_we;
    logic [3:0]  e_sel;
    logic [29:0] e_adr;
    logic [31:0] e_dw;
    bit          g;
    bit          f;
    g     = (own >= 0) && !abrt;
    f     = exp_fire();
    e_gnt = 2'b00; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_sel = '0; e_adr = '0; e_dw = '0;
    if (g && own == 0) begin
      e_gnt = 2'b01; e_cyc = m0_bus.cyc; e_stb = m0_bus.stb; e_we = m0_bus.we;
      e_sel = m0_bus.sel; e_adr = m0_bus.adr; e_dw = m0_bus.dat_w;
    end else if (g && own == 1) begin
      e_gnt = 2'b10; e_cyc = m1_bus.cyc; e_stb = m1_bus.stb; e_we = m1_bus.we;
      e_sel = m1_bus.sel; e_adr = m1_bus.adr; e_dw = m1_bus.dat_w;
    end
    chk({tag, "/gnt"},   gnt,          e_gnt);
    chk({tag, "/s_cyc"}, s_bus.cyc,    e_cyc);
    chk({tag, "/s_stb"}, s_bus.stb,    e_stb);
    chk({tag, "/s_we"},  s_bus.we,     e_we);
    chk({tag, "/s_sel"}, s_bus.sel,    e_sel);
    chk({tag, "/s_adr"}, s_bus.adr,    e_adr);
    chk({tag, "/s_dw"},  s_bus.dat_w,  e_dw);
    chk({tag, "/ack0"},  m0_bus.ack,   s_bus.ack && g && own == 0);
    chk({tag, "/ack1"},  m1_bus.ack,   s_bus.ack && g && own == 1);
    chk({tag, "/err0"},  m0_bus.err,   f && own == 0);
    chk({tag, "/err1"},  m1_bus.err,   f && own == 1);
    chk({tag, "/dr0"},   m0_bus.dat_r, s_bus.dat_r);
    chk({tag, "/dr1"},   m1_bus.dat_r, s_bus.dat_r);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m(input int x, input bit c, input bit st, input bit w,
                       input logic [3:0] sl, input logic [29:0] a, input logic [31:0] d);
    if (x == 0) begin
      m0_bus.cyc = c; m0_bus.stb = st; m0_bus.we = w;
      m0_bus.sel = sl; m0_bus.adr = a; m0_bus.dat_w = d;
    end else begin
      m1_bus.cyc = c; m1_bus.stb = st; m1_bus.we = w;
      m1_bus.sel = sl; m1_bus.adr = a; m1_bus.dat_w = d;
    end
  endtask

  task automatic set_s(input bit a, input logic [31:0] d);
    s_bus.ack   = a;
    s_bus.dat_r = d;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          done0, done1, got;
    bit          a0, a1, r0, r1, c;
    logic [31:0] ev;

    rst = 1'b1;
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_s(1'b0, 32'h0);
    s_bus.err = 1'b0;
    model_reset();

    // Reset values.
    #2 rst = 1'b0;
    #1;
    chk("rst/gnt", gnt, 2'b00);
    chk("rst/s_cyc", s_bus.cyc, 1'b0);
    chk("rst/s_stb", s_bus.stb, 1'b0);
    chk("rst/s_sel", s_bus.sel, 4'h0);
    chk("rst/s_adr", s_bus.adr, 30'h0);
    chk("rst/ack", {m1_bus.ack, m0_bus.ack}, 2'b00);
    chk("rst/err", {m1_bus.err, m0_bus.err}, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of an m0 read.
    set_m(0, 1, 1, 0, 4'hF, 30'h200, 32'h0);
    step("mid_req");
    set_s(1'b1, 32'h1234_5678);
    #1 chk("mid/ack_before", m0_bus.ack, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mid/gnt", gnt, 2'b00);
    chk("mid/s_cyc", s_bus.cyc, 1'b0);
    chk("mid/s_stb", s_bus.stb, 1'b0);
    chk("mid/s_adr", s_bus.adr, 30'h0);
    chk("mid/ack", {m1_bus.ack, m0_bus.ack}, 2'b00);
    chk("mid/err", {m1_bus.err, m0_bus.err}, 2'b00);
    model_reset();
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_m(1, 1, 1, 0, 4'hF, 30'h300, 32'h0);
    set_s(1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst");
    #1 chk("post_rst/gnt10", gnt, 2'b10);
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step("post_rst_rel");

    // Simultaneous requests: m0 first; read returns DEADBEEF.
    set_m(0, 1, 1, 0, 4'hF, 30'h0000100, 32'h0);
    set_m(1, 1, 1, 1, 4'hF, 30'h0000200, 32'h55);
    step("tie_idle");
    #1 chk("tie/gnt01", gnt, 2'b01);
    chk("tie/s_adr", s_bus.adr, 30'h0000100);
    set_s(1'b1, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    if (m0_bus.ack) chk("tie/dat_r", m0_bus.dat_r, exp_q.pop_front());
    else chk("tie/ack0", m0_bus.ack, 1'b1);
    chk("tie/ack1", m1_bus.ack, 1'b0);
    step("tie_ack");
    set_s(1'b0, 32'h0);
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step("tie_drop");
    #1 chk("tie/handover", gnt, 2'b10);
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step("tie_m1_rel");
    step("tie_idle2");

    // Locked back-to-back writes on m0 while m1 waits.
    set_m(0, 1, 1, 1, 4'b0011, 30'h10, 32'hA5A5_0001);
    set_m(1, 1, 1, 0, 4'hF, 30'h20, 32'h0);
    step("lock_req");
    step("lock_wait");
    set_s(1'b1, 32'h0);
    #1 chk("lock/sel1", s_bus.sel, 4'b0011);
    step("lock_w1");
    set_m(0, 1, 1, 1, 4'b1100, 30'h11, 32'hA5A5_0002);
    set_s(1'b0, 32'h0);
    step("lock_gap");
    #1 chk("lock/held", gnt, 2'b01);
    // Owner drops cyc in the very cycle the ack arrives.
    set_m(0, 0, 1, 1, 4'b1100, 30'h11, 32'hA5A5_0002);
    set_s(1'b1, 32'h0);
    #1;
    chk("lock/sel2", s_bus.sel, 4'b1100);
    chk("lock/ack_on_drop", m0_bus.ack, 1'b1);
    step("lock_w2");
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_s(1'b0, 32'h0);
    #1 chk("lock/m1_now", gnt, 2'b10);
    step("lock_m1");
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step("lock_rel");
    step("lock_idle");

    // Continuous single-transfer requests from both: grants alternate.
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(k % 2));
    done0 = 0; done1 = 0; a0 = 1'b0; a1 = 1'b0;
    for (int t = 0; t < 80 && (done0 + done1) < 8; t++) begin
      r0 = (done0 < 4) && !a0;
      r1 = (done1 < 4) && !a1;
      set_m(0, r0, r0, 0, 4'hF, 30'(t), 32'h0);
      set_m(1, r1, r1, 0, 4'hF, 30'(t + 100), 32'h0);
      #1 set_s(s_bus.stb, $urandom());
      #1;
      a0 = m0_bus.ack;
      a1 = m1_bus.ack;
      if (a0 || a1) begin
        got = a1 ? 1 : 0;
        if (exp_q.size() == 0) chk("alt/extra", 1'b1, 1'b0);
        else begin
          ev = exp_q.pop_front();
          chk("alt/order", 32'(got), ev);
        end
        if (a0) done0++;
        if (a1) done1++;
      end
      step("alt");
    end
    chk("alt/m0_count", 32'(done0), 32'd4);
    chk("alt/m1_count", 32'(done1), 32'd4);
    chk("alt/queue_empty", 32'(exp_q.size()), 32'd0);
    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_s(1'b0, 32'h0);
    step("alt_drain");
    step("alt_drain2");

    // Stalled slave on m1.
    set_m(1, 1, 1, 0, 4'hF, 30'h123, 32'h0);
    step("to_req");
`ifdef WB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      #1;
      chk("to/err_pulse", m1_bus.err, 1'(k == TO - 1));
      chk("to/s_cyc_stall", s_bus.cyc, 1'b1);
      step("to_stall");
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("to/abort_scyc", s_bus.cyc, 1'b0);
      chk("to/abort_err", m1_bus.err, 1'b0);
      chk("to/abort_gnt", gnt, 2'b00);
      step("to_abort");
    end
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step("to_rel");
    #1 chk("to/idle", gnt, 2'b00);
    step("to_idle");
    // Ack exactly in the threshold cycle wins.
    set_m(1, 1, 1, 0, 4'hF, 30'h124, 32'h0);
    step("to2_req");
    for (int k = 0; k < TO - 1; k++) step("to2_stall");
    set_s(1'b1, 32'h0BAD_F00D);
    #1;
    chk("to2/ack", m1_bus.ack, 1'b1);
    chk("to2/err", m1_bus.err, 1'b0);
    step("to2_ack");
    set_s(1'b0, 32'h0);
    #1;
    chk("to2/still_gnt", gnt, 2'b10);
    chk("to2/still_scyc", s_bus.cyc, 1'b1);
    step("to2_after");
`else
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("stall/no_err", m1_bus.err, 1'b0);
      chk("stall/s_cyc", s_bus.cyc, 1'b1);
      step("stall");
    end
`endif
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    step("stall_rel");
    step("stall_idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int x = 0; x < 2; x++) begin
        c = cyc_of(x) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
        set_m(x, c, c && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 30'($urandom()), $urandom());
      end
      set_s($urandom_range(0, 2) == 0, $urandom());
      step("rnd");
    end

    set_m(0, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 30'h0, 32'h0);
    set_s(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
